spell_stack_unit: RTL and testbench

//   Parametrised data stack for the spell core family. Replaces the fixed
//   32x8 stack array and bare SP register with one block. Block features:
//   - configurable width and depth
//   - one-cycle pop-0..2/push-0..2 ops driven by the execute stage
//   - optional overflow/underflow checking with sticky error flags
//   - Wishbone debug window for SP, top, push and random-access peek/poke

---
 rtl/spell_stack_unit.sv | 136 +++++++++++++
 tb/tb_spell_stack_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spell_stack_unit.sv
// Parametrised data stack: one-cycle pop/push ops from execute, optional range checking, Wishbone debug window.
// Core ops commit at the clock edge; a WB write stalls the core for that cycle via op_ready.
module spell_stack_unit #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 32,
  parameter int CHECKED = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [1:0]               op_pop,
  input  logic [1:0]               op_push,
  input  logic [WIDTH-1:0]         op_top,
  input  logic [WIDTH-1:0]         op_belowtop,
  output logic [WIDTH-1:0]         top,
  output logic [WIDTH-1:0]         belowtop,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     err_ovf,
  output logic                     err_unf,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [7:0]               i_wb_addr,
  input  logic [31:0]              i_wb_data,
  output logic                     o_wb_ack,
  output logic [31:0]              o_wb_data
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW:0]   DEPTH_N = (SPW+1)'(DEPTH);
  localparam logic [SPW-1:0] DEPTH_S = SPW'(DEPTH);
  localparam bit CHK = (CHECKED != 0);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [AW-1:0]    index_q;
  logic             ovf_q, unf_q, ack_q;
  logic [31:0]      rdata_q;

  logic [AW-1:0]    top_idx, bt_idx, idx1, idx2;
  logic [SPW:0]     nsp, pop_x, push_x;
  logic             unf_hit, ovf_hit, op_fire, op_commit;
  logic             wb_req, wb_wr, wb_rd, wb_ovf;
  logic [1:0]       clr;
  logic             ovf_d, unf_d;
  logic [SPW-1:0]   sp_load, sp_inc, sp_core;
  logic [31:0]      rdata_d;

  assign top_idx  = sp_q[AW-1:0] - AW'(1);
  assign bt_idx   = sp_q[AW-1:0] - AW'(2);
  assign top      = (CHK && sp_q == '0) ? '0 : stack_q[top_idx];
  assign belowtop = (CHK && sp_q < SPW'(2)) ? '0 : stack_q[bt_idx];
  assign sp       = sp_q;
  assign full     = CHK && (sp_q == DEPTH_S);
  assign empty    = (sp_q == '0);
  assign err_ovf  = ovf_q;
  assign err_unf  = unf_q;
  assign o_wb_ack = ack_q;
  assign o_wb_data = rdata_q;

  // One extra bit so both a negative result and an overshoot past DEPTH are visible.
  assign pop_x     = {{(SPW-1){1'b0}}, op_pop};
  assign push_x    = {{(SPW-1){1'b0}}, op_push};
  assign nsp       = {1'b0, sp_q} - pop_x + push_x;
  assign unf_hit   = CHK && (pop_x > {1'b0, sp_q});
  assign ovf_hit   = CHK && !unf_hit && (nsp > DEPTH_N);
  assign idx1      = nsp[AW-1:0] - AW'(1);
  assign idx2      = nsp[AW-1:0] - AW'(2);
  assign op_fire   = op_valid && op_ready;
  assign op_commit = op_fire && !unf_hit && !ovf_hit;

  assign wb_req   = i_wb_cyc && i_wb_stb && !ack_q;
  assign wb_wr    = wb_req && i_wb_we;
  assign wb_rd    = wb_req && !i_wb_we;
  assign op_ready = !wb_wr;
  assign wb_ovf   = wb_wr && (i_wb_addr == 8'h08) && full;

  // Flag clears lose to a set landing in the same cycle.
  assign clr   = (wb_wr && i_wb_addr == 8'h0C) ? i_wb_data[1:0] : 2'b00;
  assign ovf_d = (ovf_q && !clr[0]) || (op_fire && ovf_hit) || wb_ovf;
  assign unf_d = (unf_q && !clr[1]) || (op_fire && unf_hit);

  assign sp_load = CHK ? ((i_wb_data > 32'(DEPTH)) ? DEPTH_S : i_wb_data[SPW-1:0])
                       : {1'b0, i_wb_data[AW-1:0]};
  assign sp_inc  = CHK ? (sp_q + SPW'(1)) : {1'b0, sp_q[AW-1:0] + AW'(1)};
  assign sp_core = CHK ? nsp[SPW-1:0] : {1'b0, nsp[AW-1:0]};

  always_comb begin
    rdata_d = '0;
    case (i_wb_addr)
      8'h00:   rdata_d = 32'(sp_q);
      8'h04:   rdata_d = 32'(top);
      8'h0C:   rdata_d = {28'b0, full, empty, unf_q, ovf_q};
      8'h10:   rdata_d = 32'(index_q);
      8'h14:   rdata_d = 32'(stack_q[index_q]);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q    <= '0;
      index_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ack_q   <= wb_req;
      rdata_q <= wb_rd ? rdata_d : '0;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (wb_wr) begin
        case (i_wb_addr)
          8'h00: sp_q <= sp_load;
          8'h04: if (!(CHK && sp_q == '0)) stack_q[top_idx] <= i_wb_data[WIDTH-1:0];
          8'h08: if (!full) begin
            stack_q[sp_q[AW-1:0]] <= i_wb_data[WIDTH-1:0];
            sp_q <= sp_inc;
          end
          8'h10: index_q <= i_wb_data[AW-1:0];
          8'h14: stack_q[index_q] <= i_wb_data[WIDTH-1:0];
          default: ;
        endcase
      end else if (op_commit) begin
        sp_q <= sp_core;
        if (op_push != 2'd0) stack_q[idx1] <= op_top;
        if (op_push == 2'd2) stack_q[idx2] <= op_belowtop;
      end
    end
  end
endmodule

// File: tb/tb_spell_stack_unit.sv
// Directed bench: a checked and a wrapping 4-deep stack driven with the same stimulus.
module tb_spell_stack_unit;
  logic clock = 1'b0;
  logic reset;
  logic op_valid;
  logic [1:0] op_pop, op_push;
  logic [7:0] op_top, op_belowtop;
  logic i_wb_cyc, i_wb_stb, i_wb_we;
  logic [7:0] i_wb_addr;
  logic [31:0] i_wb_data;

  logic rdy_c, rdy_w, full_c, full_w, empty_c, empty_w;
  logic ovf_c, ovf_w, unf_c, unf_w, ack_c, ack_w;
  logic [7:0] top_c, top_w, bt_c, bt_w;
  logic [2:0] sp_c, sp_w;
  logic [31:0] rd_c, rd_w;

  int total = 0;
  int bad = 0;
  logic [31:0] vc, vw;

  always #5 clock = ~clock;

  spell_stack_unit #(.WIDTH(8), .DEPTH(4), .CHECKED(1)) u_chk (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(rdy_c),
    .op_pop(op_pop), .op_push(op_push), .op_top(op_top), .op_belowtop(op_belowtop),
    .top(top_c), .belowtop(bt_c), .sp(sp_c), .full(full_c), .empty(empty_c),
    .err_ovf(ovf_c), .err_unf(unf_c),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(ack_c), .o_wb_data(rd_c));

  spell_stack_unit #(.WIDTH(8), .DEPTH(4), .CHECKED(0)) u_wrap (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(rdy_w),
    .op_pop(op_pop), .op_push(op_push), .op_top(op_top), .op_belowtop(op_belowtop),
    .top(top_w), .belowtop(bt_w), .sp(sp_w), .full(full_w), .empty(empty_w),
    .err_ovf(ovf_w), .err_unf(unf_w),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(ack_w), .o_wb_data(rd_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic core_op(input logic [1:0] p, input logic [1:0] q,
                         input logic [7:0] t, input logic [7:0] b);
    op_valid = 1'b1; op_pop = p; op_push = q; op_top = t; op_belowtop = b;
    tick();
    op_valid = 1'b0; op_pop = 2'd0; op_push = 2'd0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    tick();
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] dc, output logic [31:0] dw);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    tick();
    chk("rd_ack", 32'(ack_c), 32'd1);
    dc = rd_c;
    dw = rd_w;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_pop = 2'd0; op_push = 2'd0;
    op_top = 8'h00; op_belowtop = 8'h00;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_addr = 8'h00; i_wb_data = 32'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_sp", 32'(sp_c), 32'd0);
    chk("rst_top", 32'(top_c), 32'd0);
    chk("rst_empty", 32'(empty_c), 32'd1);
    chk("rst_full", 32'(full_c), 32'd0);
    chk("rst_flags", {30'd0, unf_c, ovf_c}, 32'd0);
    chk("rst_ack", 32'(ack_c), 32'd0);
    chk("rst_rdata", rd_c, 32'd0);

    // Three single pushes.
    core_op(2'd0, 2'd1, 8'h11, 8'h00);
    core_op(2'd0, 2'd1, 8'h22, 8'h00);
    core_op(2'd0, 2'd1, 8'h33, 8'h00);
    chk("push3_sp", 32'(sp_c), 32'd3);
    chk("push3_top", 32'(top_c), 32'h33);
    chk("push3_bt", 32'(bt_c), 32'h22);

    // {5,7} then pop2/push1 in one cycle.
    wb_write(8'h00, 32'd0);
    core_op(2'd0, 2'd1, 8'h05, 8'h00);
    core_op(2'd0, 2'd1, 8'h07, 8'h00);
    core_op(2'd2, 2'd1, 8'h0C, 8'h00);
    chk("p2p1_sp", 32'(sp_c), 32'd1);
    chk("p2p1_top", 32'(top_c), 32'h0C);
    chk("p2p1_bt", 32'(bt_c), 32'h00);
    core_op(2'd1, 2'd2, 8'hAA, 8'hBB);
    chk("p1p2_sp", 32'(sp_c), 32'd2);
    chk("p1p2_top", 32'(top_c), 32'hAA);
    chk("p1p2_bt", 32'(bt_c), 32'hBB);

    // Underflow on empty stack, then W1C.
    wb_write(8'h00, 32'd0);
    core_op(2'd1, 2'd1, 8'h44, 8'h00);
    chk("unf_sp", 32'(sp_c), 32'd0);
    chk("unf_flag", 32'(unf_c), 32'd1);
    chk("unf_wrap_flag", 32'(unf_w), 32'd0);
    wb_read(8'h0C, vc, vw);
    chk("unf_status", vc, 32'h6);
    wb_write(8'h0C, 32'h2);
    chk("unf_clear", 32'(unf_c), 32'd0);

    // Fill to DEPTH, then overflow through WB PUSH and through the core.
    core_op(2'd0, 2'd1, 8'hA0, 8'h00);
    core_op(2'd0, 2'd1, 8'hA1, 8'h00);
    core_op(2'd0, 2'd1, 8'hA2, 8'h00);
    core_op(2'd0, 2'd1, 8'hA3, 8'h00);
    chk("fill_sp", 32'(sp_c), 32'd4);
    chk("fill_full", 32'(full_c), 32'd1);
    chk("fill_wrap_sp", 32'(sp_w), 32'd0);
    wb_write(8'h08, 32'h99);
    chk("wbovf_sp", 32'(sp_c), 32'd4);
    chk("wbovf_flag", 32'(ovf_c), 32'd1);
    chk("wbovf_top", 32'(top_c), 32'hA3);
    chk("wrap_push_sp", 32'(sp_w), 32'd1);
    chk("wrap_push_full", 32'(full_w), 32'd0);
    chk("wrap_push_flag", 32'(ovf_w), 32'd0);
    wb_write(8'h10, 32'd0);
    wb_read(8'h14, vc, vw);
    chk("wbovf_entry0", vc, 32'hA0);
    chk("wrap_entry0", vw, 32'h99);
    wb_write(8'h0C, 32'h1);
    chk("ovf_clear", 32'(ovf_c), 32'd0);
    core_op(2'd0, 2'd1, 8'hEE, 8'h00);
    chk("coreovf_sp", 32'(sp_c), 32'd4);
    chk("coreovf_flag", 32'(ovf_c), 32'd1);
    chk("coreovf_top", 32'(top_c), 32'hA3);
    chk("wrap_core_top", 32'(top_w), 32'hEE);

    // WB SP write collides with a core push: WB wins.
    op_valid = 1'b1; op_pop = 2'd0; op_push = 2'd1; op_top = 8'h55;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = 8'h00; i_wb_data = 32'd2;
    #1;
    chk("coll_ready", 32'(rdy_c), 32'd0);
    chk("coll_ack_before", 32'(ack_c), 32'd0);
    tick();
    chk("coll_ack", 32'(ack_c), 32'd1);
    chk("coll_sp", 32'(sp_c), 32'd2);
    chk("coll_top", 32'(top_c), 32'hA1);
    op_valid = 1'b0; op_push = 2'd0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    tick();
    chk("coll_ack_after", 32'(ack_c), 32'd0);
    chk("coll_sp_after", 32'(sp_c), 32'd2);

    // A read never stalls the core.
    op_valid = 1'b1; op_push = 2'd0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 8'h00;
    #1;
    chk("rd_ready", 32'(rdy_c), 32'd1);
    op_valid = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick(); tick();

    // TOP write, raw INDEX/DATA access, unmapped address.
    wb_write(8'h04, 32'h77);
    chk("topw_top", 32'(top_c), 32'h77);
    wb_write(8'h10, 32'd3);
    wb_write(8'h14, 32'hAB);
    wb_read(8'h14, vc, vw);
    chk("data_rd", vc, 32'hAB);
    wb_read(8'h10, vc, vw);
    chk("index_rd", vc, 32'd3);
    wb_read(8'h00, vc, vw);
    chk("data_sp", vc, 32'd2);
    wb_read(8'h20, vc, vw);
    chk("unmapped_rd", vc, 32'd0);

    // Reset lands on an accepted read.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 8'h14;
    reset = 1'b1;
    tick();
    chk("midrst_ack", 32'(ack_c), 32'd0);
    chk("midrst_sp", 32'(sp_c), 32'd0);
    reset = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
